reg_file: RTL

- 32-entry by 64-bit architectural register file for the pipelined ARM (LEGv8) core.
- Two asynchronous read ports and one synchronous write port.
- Sits directly downstream of the per-bit enabled flip-flop: every storage bit is an enable-gated D flip-flop, and this block supplies the per-register write enables.
- Read in ID, written from WB; includes write-through bypass so that a same-cycle WB write is visible to ID.

---
 rtl/arm_pkg.sv | 13 +
 rtl/reg_file_if.sv | 28 ++
 rtl/d_ff_en.sv | 17 +
 rtl/en_register.sv | 22 ++
 rtl/reg_file.sv | 53 +++++
 5 files changed

// File: rtl/arm_pkg.sv
// arm_pkg: shared register-file sizing constants and types for the LEGv8 core
//    REG_WIDTH  data width of an architectural register
//    REG_AW     register address width
//    NUM_REGS   number of architectural registers (2^REG_AW)
//    XZR        index of the hardwired zero register
package arm_pkg;
   localparam int REG_WIDTH = 64;
   localparam int REG_AW = 5;
   localparam int NUM_REGS = 32;
   localparam logic [4:0] XZR = 5'd31;
   typedef logic [4:0] reg_addr_t;
   typedef logic [63:0] reg_data_t;
endpackage

// File: rtl/reg_file_if.sv
// reg_file_if: write-back and decode-stage bus of the register file
//    RegWrite       write enable from WB
//    WriteRegister  write address
//    WriteData      write data
//    ReadRegister1  read address, port 1
//    ReadRegister2  read address, port 2
//    ReadData1      read data, port 1
//    ReadData2      read data, port 2
//    master drives addresses/write data, slave (the register file) drives read data
interface reg_file_if
   import arm_pkg::*;
;
   logic RegWrite;
   reg_addr_t WriteRegister;
   reg_data_t WriteData;
   reg_addr_t ReadRegister1;
   reg_addr_t ReadRegister2;
   reg_data_t ReadData1;
   reg_data_t ReadData2;
   modport master(
      output RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      input ReadData1, ReadData2
   );
   modport slave(
      input RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
      output ReadData1, ReadData2
   );
endinterface

// File: rtl/d_ff_en.sv
// d_ff_en: single enable-gated D flip-flop with asynchronous active-high reset
//    clk    rising-edge clock
//    reset  asynchronous clear
//    en     load enable
//    d      data in
//    q      stored bit
module d_ff_en (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic d,
   output logic q
);
   always_ff @(posedge clk or posedge reset)
      if (reset) q <= 1'b0;
      else if (en) q <= d;
endmodule

// File: rtl/en_register.sv
// en_register: WIDTH-bit enabled register built from per-bit enabled flip-flops
//    clk    rising-edge clock
//    reset  asynchronous clear
//    en     load enable shared by every bit
//    d      data in
//    q      stored word
module en_register #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   genvar b;
   generate
      for (b = 0; b < WIDTH; b++) begin : g_bit
         d_ff_en u_ff (.clk(clk), .reset(reset), .en(en), .d(d[b]), .q(q[b]));
      end
   endgenerate
endmodule

// File: rtl/reg_file.sv
// reg_file: 32x64 register file, two combinational read ports, one write port, WB->ID bypass
//    clk    rising-edge clock
//    reset  asynchronous active-high clear; forces both read ports to zero while high
//    rf     slave side of reg_file_if (write port in, read addresses in, read data out)
module reg_file
   import arm_pkg::*;
#(
   parameter int WIDTH = REG_WIDTH,
   parameter int NREGS = NUM_REGS,
   parameter int AW = REG_AW,
   parameter int ZERO_REG = int'(XZR)
) (
   input logic clk,
   input logic reset,
   reg_file_if.slave rf
);
   logic [WIDTH-1:0] stored [NREGS];
   logic [WIDTH-1:0] tree1, tree2;
   genvar i;
   generate
      for (i = 0; i < NREGS; i++) begin : g_reg
         if (i == ZERO_REG) begin : g_zero
            // XZR has no storage; the constant leaf keeps the mux tree uniform
            assign stored[i] = '0;
         end else begin : g_store
            logic en;
            assign en = rf.RegWrite && (rf.WriteRegister == AW'(i));
            en_register #(.WIDTH(WIDTH)) u_reg (
               .clk(clk), .reset(reset), .en(en), .d(rf.WriteData), .q(stored[i])
            );
         end
      end
   endgenerate
   // Binary tree of 2:1 muxes: stage k halves the candidates using address bit k
   function automatic logic [WIDTH-1:0] tree_read(input logic [AW-1:0] a,
                                                  input logic [WIDTH-1:0] s [NREGS]);
      logic [WIDTH-1:0] t [NREGS];
      t = s;
      for (int k = 0; k < AW; k++)
         for (int p = 0; p < (NREGS >> (k + 1)); p++)
            t[p] = a[k] ? t[2*p+1] : t[2*p];
      return t[0];
   endfunction
   always_comb begin
      tree1 = tree_read(rf.ReadRegister1, stored);
      tree2 = tree_read(rf.ReadRegister2, stored);
   end
   // XZR and reset win over the bypass, the bypass wins over storage
   assign rf.ReadData1 = (reset || rf.ReadRegister1 == AW'(ZERO_REG)) ? '0 :
                         (rf.RegWrite && rf.WriteRegister == rf.ReadRegister1) ? rf.WriteData : tree1;
   assign rf.ReadData2 = (reset || rf.ReadRegister2 == AW'(ZERO_REG)) ? '0 :
                         (rf.RegWrite && rf.WriteRegister == rf.ReadRegister2) ? rf.WriteData : tree2;
endmodule
